// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the pipelined N:1 select tree
package mux_pkg;

  localparam int MAX_IN   = 64;
  localparam int MAX_LVLS = 6;

  // ceil(log2(n)); returns 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_tree_lvl.sv
// rtl/mux_tree_lvl.sv - one level of 2:1 muxes with an optional stall/flush register
module mux_tree_lvl
  import mux_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NIN_LVL = 2,
  parameter bit REG     = 1'b0,
  parameter int SEL_W   = 1,
  parameter int SEL_IDX = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [NIN_LVL*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_valid,
  input  logic                       in_err,
  output logic [NIN_LVL/2*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_valid,
  output logic                       out_err
);

  localparam int NOUT = NIN_LVL / 2;

  typedef struct packed {
    logic [NOUT*WIDTH-1:0] data;
    logic [SEL_W-1:0]      sel_rem;
    logic                  valid;
    logic                  err;
  } bundle_t;

  logic [NOUT*WIDTH-1:0] mux_data;
  bundle_t               lvl_in;

  // pairwise select: output j takes input 2j or 2j+1 on this level's sel bit
  always_comb begin
    mux_data = '0;
    for (int j = 0; j < NOUT; j++) begin
      mux_data[j*WIDTH +: WIDTH] = in_sel[SEL_IDX] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                                                   : in_data[(2*j)*WIDTH +: WIDTH];
    end
  end

  assign lvl_in = '{data: mux_data, sel_rem: in_sel, valid: in_valid, err: in_err};

  generate
    if (REG) begin : g_reg
      bundle_t bundle_d;
      bundle_t bundle_q;

      // flush kills valid but keeps data/err; stall holds everything
      always_comb begin
        bundle_d = bundle_q;
        if (flush) begin
          bundle_d.valid = 1'b0;
        end else if (!stall) begin
          bundle_d = lvl_in;
        end
      end

      // level register, cleared asynchronously
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bundle_q <= '0;
        end else begin
          bundle_q <= bundle_d;
        end
      end

      assign out_data  = bundle_q.data;
      assign out_sel   = bundle_q.sel_rem;
      assign out_valid = bundle_q.valid;
      assign out_err   = bundle_q.err;
    end else begin : g_comb
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, reset_n, stall, flush};

      assign out_data  = lvl_in.data;
      assign out_sel   = lvl_in.sel_rem;
      assign out_valid = lvl_in.valid;
      assign out_err   = lvl_in.err;
    end
  endgenerate

endmodule

// File: rtl/mux_pipe_n1.sv
// rtl/mux_pipe_n1.sv - parametrised N:1 select tree with per-level pipeline registers
module mux_pipe_n1
  import mux_pkg::*;
#(
  parameter int                            WIDTH   = 64,
  parameter int                            NUM_IN  = 8,
  parameter logic [clog2(NUM_IN)-1:0]      LVL_REG = 3'b101
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [clog2(NUM_IN)-1:0]    sel,
  input  logic [NUM_IN*WIDTH-1:0]     in_data,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_sel_err
);

  localparam int LVLS = clog2(NUM_IN);
  localparam int PAD  = 1 << LVLS;
  localparam int PADW = PAD * WIDTH;

  generate
    if (NUM_IN < 2 || NUM_IN > MAX_IN) begin : g_bad_num_in
      $error("mux_pipe_n1: NUM_IN must be in 2..64");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("mux_pipe_n1: WIDTH must be at least 1");
    end
  endgenerate

  logic [PADW-1:0] lvl_data  [0:LVLS];
  logic [LVLS-1:0] lvl_sel   [0:LVLS];
  logic            lvl_valid [0:LVLS];
  logic            lvl_err   [0:LVLS];

  // zero padding makes any out-of-range sel land on an all-zero leaf,
  // so err results carry zero data without an explicit mask
  assign lvl_data[0]  = PADW'(in_data);
  assign lvl_sel[0]   = sel;
  assign lvl_valid[0] = in_valid;
  assign lvl_err[0]   = 32'(sel) >= NUM_IN;

  generate
    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
      localparam int NIN_K  = PAD >> k;
      localparam int NOUT_K = NIN_K / 2;

      logic [NOUT_K*WIDTH-1:0] lo_data;
      logic                    unused_hi;

      mux_tree_lvl #(
        .WIDTH   (WIDTH),
        .NIN_LVL (NIN_K),
        .REG     (LVL_REG[k]),
        .SEL_W   (LVLS),
        .SEL_IDX (k)
      ) u_lvl (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (flush),
        .in_data   (lvl_data[k][NIN_K*WIDTH-1:0]),
        .in_sel    (lvl_sel[k]),
        .in_valid  (lvl_valid[k]),
        .in_err    (lvl_err[k]),
        .out_data  (lo_data),
        .out_sel   (lvl_sel[k+1]),
        .out_valid (lvl_valid[k+1]),
        .out_err   (lvl_err[k+1])
      );

      assign lvl_data[k+1] = PADW'(lo_data);
      assign unused_hi     = |lvl_data[k+1][PADW-1:NOUT_K*WIDTH];
    end
  endgenerate

  logic unused_sel;
  assign unused_sel = &{1'b0, lvl_sel[LVLS]};

  assign out_valid   = lvl_valid[LVLS];
  assign out_data    = lvl_data[LVLS][WIDTH-1:0];
  assign out_sel_err = lvl_err[LVLS];

endmodule
